// File: rtl/awgn_noise_injector.sv
// AWGN channel model: scales Gaussian noise by a Q4.12 gain and adds it to a Q1.15 valid/ready
// stream with saturation. Optional macro AWGN_SAT_CNT_EN adds the sat_clr/sat_count counter.
module awgn_noise_injector #(
  parameter int DW        = 16,
  parameter int GW        = 16,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        noise_in,
  input  logic [GW-1:0]        noise_gain,
  input  logic                 noise_en,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_sat,
  input  logic                 out_ready,
`ifdef AWGN_SAT_CNT_EN
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count,
`endif
  output logic                 out_valid
);

  localparam int PW   = DW + GW + 1;  // exact signed product width
  localparam int FRAC = 12;           // Q4.12 gain fraction bits

  localparam logic signed [PW:0] HALF  = (PW+1)'(1) <<< (FRAC - 1);
  localparam logic signed [PW:0] MAX_W = (PW+1)'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [PW:0] MIN_W = ~MAX_W;
  localparam logic [DW-1:0]      MAX_D = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]      MIN_D = {1'b1, {(DW-1){1'b0}}};

  logic                 advance;
  logic                 accept;
  logic                 s1_valid;
  logic [DW-1:0]        s1_sig;
  logic signed [PW-1:0] s1_prod;
  logic                 s1_en;

  logic signed [PW:0]   rounded;
  logic signed [PW:0]   shifted;
  logic                 sat_a;
  logic [DW-1:0]        scaled;
  logic [DW:0]          sum;
  logic                 sat_b;
  logic [DW-1:0]        sum_c;

  // Both stages move together; the whole pipe freezes only when the output is held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    rounded = $signed({s1_prod[PW-1], s1_prod}) + HALF;
    shifted = rounded >>> FRAC;
    sat_a   = (shifted > MAX_W) || (shifted < MIN_W);
    scaled  = shifted[DW-1:0];
    if (sat_a) scaled = shifted[PW] ? MIN_D : MAX_D;

    sum   = {s1_sig[DW-1], s1_sig} + {scaled[DW-1], scaled};
    sat_b = sum[DW] != sum[DW-1];
    sum_c = sum[DW-1:0];
    if (sat_b) sum_c = sum[DW] ? MIN_D : MAX_D;
  end

  // NOTE: stage-1 datapath registers carry no reset; s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sig  <= in_data;
      s1_prod <= $signed(noise_in) * $signed({1'b0, noise_gain});
      s1_en   <= noise_en;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_en ? sum_c : s1_sig;
        out_sat  <= s1_en & (sat_a | sat_b);
      end
    end
  end

`ifdef AWGN_SAT_CNT_EN
  // Counts delivered saturated samples; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_awgn_noise_injector.sv
// Scoreboard bench for awgn_noise_injector: directed corner cases plus randomized traffic
// checked against an integer-arithmetic model of the channel.
module tb_awgn_noise_injector;

  localparam int DW = 16;
  localparam int GW = 16;
  localparam int SAT_CNT_W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  noise_in;
  logic [GW-1:0]  noise_gain;
  logic           noise_en;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  out_data;
  logic           out_sat;
  logic           out_valid;
  logic           out_ready;
  logic           ready_force;
  logic           rnd_ready;
  logic           rnd_bit;
`ifdef AWGN_SAT_CNT_EN
  logic                 sat_clr;
  logic [SAT_CNT_W-1:0] sat_count;
  int                   sat_model;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW:0]   sb[$];      // {sat, data} expected in delivery order
  logic          dir_use;
  logic [DW:0]   dir_exp;
  logic          hold_prev;
  logic [DW:0]   hold_val;

  always #5 clk = ~clk;

  assign out_ready = rnd_ready ? rnd_bit : ready_force;

  awgn_noise_injector #(.DW(DW), .GW(GW), .SAT_CNT_W(SAT_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .noise_in   (noise_in),
    .noise_gain (noise_gain),
    .noise_en   (noise_en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_ready  (out_ready),
`ifdef AWGN_SAT_CNT_EN
    .sat_clr    (sat_clr),
    .sat_count  (sat_count),
`endif
    .out_valid  (out_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Channel model from plain integer arithmetic: scale, round half up, clamp, add, clamp.
  function automatic logic [DW:0] model(input logic [DW-1:0] sig, input logic [DW-1:0] noise,
                                        input logic [GW-1:0] gain, input logic en);
    longint s, n, g, p, sc, sum;
    logic sat;
    s = longint'($signed(sig));
    n = longint'($signed(noise));
    g = longint'({48'd0, gain});
    if (!en) return {1'b0, sig};
    p   = n * g;
    sc  = (p + 2048) >>> 12;
    sat = 1'b0;
    if (sc > 32767)  begin sc = 32767;  sat = 1'b1; end
    if (sc < -32768) begin sc = -32768; sat = 1'b1; end
    sum = s + sc;
    if (sum > 32767)  begin sum = 32767;  sat = 1'b1; end
    if (sum < -32768) begin sum = -32768; sat = 1'b1; end
    return {sat, 16'(sum)};
  endfunction

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Monitor then accept-capture, both sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
`ifdef AWGN_SAT_CNT_EN
      sat_model = 0;
`endif
    end else begin
`ifdef AWGN_SAT_CNT_EN
      check("sat_count", 32'(sat_count), 32'(sat_model));
      if (sat_clr) sat_model = 0;
      else if (out_valid && out_ready && out_sat && sat_model != 65535) sat_model++;
`endif
      if (out_valid && !out_ready) begin
        if (hold_prev) check("stall_stable", 32'({out_sat, out_data}), 32'(hold_val));
        hold_prev = 1'b1;
        hold_val  = {out_sat, out_data};
      end else begin
        hold_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e[DW-1:0]));
          check("out_sat", 32'(out_sat), 32'(e[DW]));
        end
      end
      if (in_valid && in_ready)
        sb.push_back(dir_use ? dir_exp : model(in_data, noise_in, noise_gain, noise_en));
    end
  end

  // Presents one sample and holds it until accepted; returns just after the accepting edge.
  task automatic send(input logic [15:0] sig, input logic [15:0] noise, input logic [15:0] gain,
                      input logic en, input logic use_exp, input logic [16:0] exp);
    int budget;
    in_data  = sig;
    noise_in = noise;
    noise_gain = gain;
    noise_en = en;
    dir_use  = use_exp;
    dir_exp  = exp;
    in_valid = 1'b1;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      budget++;
      if (budget > 200) begin
        check("accept_timeout", 32'(budget), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    dir_use  = 1'b0;
    noise_in = 16'($urandom);
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    noise_in = '0;
    noise_gain = '0;
    noise_en = 1'b0;
    ready_force = 1'b1;
    rnd_ready = 1'b0;
    dir_use = 1'b0;
    dir_exp = '0;
    hold_prev = 1'b0;
    hold_val = '0;
`ifdef AWGN_SAT_CNT_EN
    sat_clr = 1'b0;
    sat_model = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sat", 32'(out_sat), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Unity gain and two-edge latency
    send(16'h1000, 16'h0100, 16'h1000, 1'b1, 1'b1, {1'b0, 16'h1100});
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Rounding half up and scale/sum saturation
    send(16'h0000, 16'h0001, 16'h0800, 1'b1, 1'b1, {1'b0, 16'h0001});
    send(16'h0000, 16'hFFFF, 16'h0800, 1'b1, 1'b1, {1'b0, 16'h0000});
    send(16'h7000, 16'h2000, 16'h1000, 1'b1, 1'b1, {1'b1, 16'h7FFF});
    send(16'h8000, 16'hF000, 16'h1000, 1'b1, 1'b1, {1'b1, 16'h8000});
    send(16'h0000, 16'h1000, 16'hF000, 1'b1, 1'b1, {1'b1, 16'h7FFF});
    send(16'h1234, 16'h1000, 16'hF000, 1'b0, 1'b1, {1'b0, 16'h1234});
    drain();

    // Backpressure: two samples held, third waits, nothing lost or repeated
    ready_force = 1'b0;
    send(16'h0100, 16'h0010, 16'h1000, 1'b1, 1'b1, {1'b0, 16'h0110});
    send(16'h0200, 16'h0020, 16'h1000, 1'b1, 1'b1, {1'b0, 16'h0220});
    in_data = 16'h0300;
    noise_in = 16'h0030;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_a", 32'(out_data), 32'h0110);
    end
    @(posedge clk);
    #1 ready_force = 1'b1;
    send(16'h0300, 16'h0030, 16'h1000, 1'b1, 1'b1, {1'b0, 16'h0330});
    drain();

    // Reset with two samples in flight discards both
    ready_force = 1'b0;
    send(16'h0400, 16'h0000, 16'h1000, 1'b1, 1'b0, '0);
    send(16'h0500, 16'h0000, 16'h1000, 1'b1, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    ready_force = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_no_emit", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef AWGN_SAT_CNT_EN
    repeat (3) send(16'h7000, 16'h2000, 16'h1000, 1'b1, 1'b0, '0);
    drain();
    check("sat_count_three", 32'(sat_count), 32'd3);
    ready_force = 1'b0;
    send(16'h7000, 16'h2000, 16'h1000, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    sat_clr = 1'b1;
    ready_force = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    check("sat_clr_wins", 32'(sat_count), 32'd0);
    drain();
`endif

    // Randomized traffic with random backpressure and idle gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] g;
      g = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h2000));
      send(16'($urandom), 16'($urandom), g, $urandom_range(0, 4) != 0, 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_ready = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
